// File: rtl/fir_pkg.sv
// Shared constants, FSM encoding and output clamp for the TDM FIR filter.
package fir_pkg;

    localparam int DATA_W_DEF  = 12;
    localparam int COEFF_W_DEF = 16;
    localparam int NTAPS_DEF   = 16;
    localparam int NCH_DEF     = 4;
    localparam int FRAC_DEF    = 13;

    typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} fir_state_t;

    // Clamp a rounded result into 0..2^data_w-1; returns {sat, value}.
    function automatic logic [32:0] clamp_u(input logic signed [63:0] acc, input int data_w);
        logic signed [63:0] max_v;
        max_v = (64'sd1 <<< data_w) - 64'sd1;
        if (acc < 64'sd0)
            clamp_u = {1'b1, 32'd0};
        else if (acc > max_v)
            clamp_u = {1'b1, max_v[31:0]};
        else
            clamp_u = {1'b0, acc[31:0]};
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Double-buffered coefficient storage: shadow bank written at any time,
// copied into the active bank only while the filter is idle.
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int COEFF_W = COEFF_W_DEF,
    parameter int NTAPS   = NTAPS_DEF,
    parameter int FRAC    = FRAC_DEF
) (
    input  logic                         CLK,
    input  logic                         RSTn,
    input  logic                         idle,
    input  logic                         coeff_we,
    input  logic [$clog2(NTAPS)-1:0]     coeff_addr,
    input  logic signed [COEFF_W-1:0]    coeff_data,
    input  logic                         coeff_swap,
    input  logic [$clog2(NTAPS)-1:0]     rd_tap,
    output logic signed [COEFF_W-1:0]    rd_coeff
);

    localparam logic signed [COEFF_W-1:0] UNITY = COEFF_W'(2 ** FRAC);

    logic signed [COEFF_W-1:0] shadow [NTAPS];
    logic signed [COEFF_W-1:0] active [NTAPS];
    logic                      pend;
    logic                      addr_ok;

    assign addr_ok  = int'(coeff_addr) < NTAPS;
    assign rd_coeff = active[rd_tap];

    // Shadow writes, sticky swap request and idle-only shadow->active copy.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < NTAPS; i++) begin
                shadow[i] <= (i == 0) ? UNITY : '0;
                active[i] <= (i == 0) ? UNITY : '0;
            end
            pend <= 1'b0;
        end else begin
            if (coeff_we && addr_ok)
                shadow[coeff_addr] <= coeff_data;
            // Copy sees the pre-write shadow because both use the old value.
            if (pend && idle)
                active <= shadow;
            pend <= coeff_swap || (pend && !idle);
        end
    end

endmodule

// File: rtl/fir_mac_tdm.sv
// Time-multiplexed multi-channel FIR: one MAC walks NTAPS taps per sample,
// then rounds, saturates and presents a one-cycle result strobe.
module fir_mac_tdm
    import fir_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int COEFF_W = COEFF_W_DEF,
    parameter int NTAPS   = NTAPS_DEF,
    parameter int NCH     = NCH_DEF,
    parameter int FRAC    = FRAC_DEF,
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW     = $clog2(NTAPS)
) (
    input  logic                      CLK,
    input  logic                      RSTn,
    input  logic                      ENABLE_FIR,
    input  logic                      IN_VALID,
    input  logic [CHW-1:0]            IN_CH,
    input  logic [DATA_W-1:0]         DATA_IN,
    output logic                      IN_READY,
    output logic                      OUT_VALID,
    output logic [CHW-1:0]            OUT_CH,
    output logic [DATA_W-1:0]         DATA_OUT,
    output logic                      SAT,
    input  logic                      COEFF_WE,
    input  logic [AW-1:0]             COEFF_ADDR,
    input  logic signed [COEFF_W-1:0] COEFF_DATA,
    input  logic                      COEFF_SWAP
);

    localparam int ACC_W = DATA_W + COEFF_W + $clog2(NTAPS) + 1;
    localparam int PW    = DATA_W + COEFF_W + 1;

    fir_state_t state, state_nxt;

    logic                      accept, ch_ok;
    logic [DATA_W-1:0]         dline [NCH][NTAPS];
    logic [AW-1:0]             wptr  [NCH];
    logic [AW-1:0]             tap_p0, ptr_p0, rd_idx;
    logic [CHW-1:0]            ch_p0;
    logic [DATA_W-1:0]         smp_p0;
    logic                      byp_p0;
    logic signed [ACC_W-1:0]   acc_p0;
    logic signed [COEFF_W-1:0] coeff;
    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   y_round;
    logic [32:0]               clamp_res;
    logic                      vld_p1;

    function automatic logic signed [ACC_W-1:0] round_acc(input logic signed [ACC_W-1:0] a);
        round_acc = (a + ACC_W'(2 ** (FRAC - 1))) >>> FRAC;
    endfunction

    assign ch_ok     = int'(IN_CH) < NCH;
    assign accept    = IN_VALID && IN_READY;
    assign rd_idx    = AW'((ptr_p0 >= tap_p0) ? (int'(ptr_p0) - int'(tap_p0))
                                              : (int'(ptr_p0) + NTAPS - int'(tap_p0)));
    assign prod      = $signed({1'b0, dline[ch_p0][rd_idx]}) * coeff;
    assign y_round   = round_acc(acc_p0);
    assign clamp_res = clamp_u(64'(y_round), DATA_W);
    assign OUT_VALID = vld_p1;

    fir_coeff_bank #(
        .COEFF_W (COEFF_W),
        .NTAPS   (NTAPS),
        .FRAC    (FRAC)
    ) u_coeff_bank (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .idle       (state == IDLE),
        .coeff_we   (COEFF_WE),
        .coeff_addr (COEFF_ADDR),
        .coeff_data (COEFF_DATA),
        .coeff_swap (COEFF_SWAP),
        .rd_tap     (tap_p0),
        .rd_coeff   (coeff)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state and ready; samples for unknown channels are swallowed in IDLE.
    always_comb begin
        state_nxt = state;
        IN_READY  = 1'b0;
        case (state)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID && ch_ok)
                    state_nxt = MAC;
            end
            MAC:     if (tap_p0 == AW'(NTAPS - 1)) state_nxt = ROUND;
            ROUND:   state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Per-channel circular delay lines, written on every accepted sample.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int c = 0; c < NCH; c++) begin
                wptr[c] <= '0;
                for (int t = 0; t < NTAPS; t++)
                    dline[c][t] <= '0;
            end
        end else if (accept && ch_ok) begin
            dline[IN_CH][wptr[IN_CH]] <= DATA_IN;
            wptr[IN_CH] <= (wptr[IN_CH] == AW'(NTAPS - 1)) ? '0 : wptr[IN_CH] + 1'b1;
        end
    end

    // Stage p0: capture the accepted sample context, then accumulate one tap per cycle.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            acc_p0 <= '0;
            tap_p0 <= '0;
            ptr_p0 <= '0;
            ch_p0  <= '0;
            smp_p0 <= '0;
            byp_p0 <= 1'b0;
        end else if (accept && ch_ok) begin
            acc_p0 <= '0;
            tap_p0 <= '0;
            ptr_p0 <= wptr[IN_CH];
            ch_p0  <= IN_CH;
            smp_p0 <= DATA_IN;
            byp_p0 <= !ENABLE_FIR;
        end else if (state == MAC) begin
            acc_p0 <= acc_p0 + ACC_W'(prod);
            tap_p0 <= tap_p0 + 1'b1;
        end
    end

    // Stage p1: round, saturate (or bypass) and register the result with its strobe.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            vld_p1   <= 1'b0;
            DATA_OUT <= '0;
            OUT_CH   <= '0;
            SAT      <= 1'b0;
        end else begin
            vld_p1 <= (state == ROUND);
            if (state == ROUND) begin
                OUT_CH   <= ch_p0;
                DATA_OUT <= byp_p0 ? smp_p0 : DATA_W'(clamp_res[31:0]);
                SAT      <= byp_p0 ? 1'b0 : clamp_res[32];
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_tdm.sv
// Directed bench for fir_mac_tdm with a queue-based scoreboard.
module tb_fir_mac_tdm;

    localparam int DATA_W  = 12;
    localparam int COEFF_W = 16;
    localparam int NTAPS   = 16;
    localparam int NCH     = 4;
    localparam int FRAC    = 13;

    logic                      CLK = 1'b0;
    logic                      RSTn;
    logic                      ENABLE_FIR;
    logic                      IN_VALID;
    logic [1:0]                IN_CH;
    logic [DATA_W-1:0]         DATA_IN;
    logic                      IN_READY;
    logic                      OUT_VALID;
    logic [1:0]                OUT_CH;
    logic [DATA_W-1:0]         DATA_OUT;
    logic                      SAT;
    logic                      COEFF_WE;
    logic [3:0]                COEFF_ADDR;
    logic signed [COEFF_W-1:0] COEFF_DATA;
    logic                      COEFF_SWAP;

    typedef struct packed {
        logic [1:0]        ch;
        logic [DATA_W-1:0] data;
        logic              sat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    fir_mac_tdm #(
        .DATA_W  (DATA_W),
        .COEFF_W (COEFF_W),
        .NTAPS   (NTAPS),
        .NCH     (NCH),
        .FRAC    (FRAC)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .ENABLE_FIR (ENABLE_FIR),
        .IN_VALID   (IN_VALID),
        .IN_CH      (IN_CH),
        .DATA_IN    (DATA_IN),
        .IN_READY   (IN_READY),
        .OUT_VALID  (OUT_VALID),
        .OUT_CH     (OUT_CH),
        .DATA_OUT   (DATA_OUT),
        .SAT        (SAT),
        .COEFF_WE   (COEFF_WE),
        .COEFF_ADDR (COEFF_ADDR),
        .COEFF_DATA (COEFF_DATA),
        .COEFF_SWAP (COEFF_SWAP)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every result strobe is matched against the oldest expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (RSTn && OUT_VALID) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", int'(DATA_OUT), int'(e.data));
                check("out_ch",   int'(OUT_CH),   int'(e.ch));
                check("out_sat",  int'(SAT),      int'(e.sat));
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_in_ready",  int'(IN_READY),  1);
        check("rst_out_valid", int'(OUT_VALID), 0);
        check("rst_data_out",  int'(DATA_OUT),  0);
        check("rst_out_ch",    int'(OUT_CH),    0);
        check("rst_sat",       int'(SAT),       0);
    endtask

    task automatic load_tap(input int addr, input int val);
        COEFF_WE   = 1'b1;
        COEFF_ADDR = addr[3:0];
        COEFF_DATA = val[15:0];
        @(negedge CLK);
        COEFF_WE   = 1'b0;
    endtask

    task automatic swap();
        COEFF_SWAP = 1'b1;
        @(negedge CLK);
        COEFF_SWAP = 1'b0;
        @(negedge CLK);
    endtask

    // Issue one sample, queue its expected result and verify handshake timing.
    task automatic send(input int ch, input int data, input bit en, input int exp_d,
                        input bit exp_s, input bit mid_swap, input int mid_val);
        int   n = 0;
        bit   tim_ok = 1'b1;
        exp_t e;
        while (!IN_READY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!IN_READY) begin
            check("ready_timeout", 0, 1);
            return;
        end
        IN_VALID   = 1'b1;
        IN_CH      = ch[1:0];
        DATA_IN    = data[DATA_W-1:0];
        ENABLE_FIR = en;
        e.ch   = ch[1:0];
        e.data = exp_d[DATA_W-1:0];
        e.sat  = exp_s;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        IN_VALID   = 1'b0;
        ENABLE_FIR = 1'b1;
        for (int i = 1; i <= NTAPS + 3; i++) begin
            @(negedge CLK);
            if (IN_READY !== (i == NTAPS + 3) || OUT_VALID !== (i == NTAPS + 2))
                tim_ok = 1'b0;
            if (mid_swap && i == 2) begin
                COEFF_WE   = 1'b1;
                COEFF_ADDR = 4'd0;
                COEFF_DATA = mid_val[15:0];
                COEFF_SWAP = 1'b1;
            end
            if (mid_swap && i == 3) begin
                COEFF_WE   = 1'b0;
                COEFF_SWAP = 1'b0;
            end
        end
        check("timing", int'(tim_ok), 1);
    endtask

    initial begin
        bit seen;
        int n;
        RSTn       = 1'b0;
        ENABLE_FIR = 1'b1;
        IN_VALID   = 1'b0;
        IN_CH      = '0;
        DATA_IN    = '0;
        COEFF_WE   = 1'b0;
        COEFF_ADDR = '0;
        COEFF_DATA = '0;
        COEFF_SWAP = 1'b0;
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        check_reset_vals();

        // Identity impulse.
        send(0, 4095, 1'b1, 4095, 1'b0, 1'b0, 0);

        // Moving average over 16 taps on ch2, ramping up to the input level.
        for (int t = 0; t < NTAPS; t++) load_tap(t, 512);
        swap();
        for (int k = 1; k <= 16; k++) send(2, 1600, 1'b1, k * 100, 1'b0, 1'b0, 0);
        // Ch1 history is empty, independent of ch2.
        send(1, 800, 1'b1, 50, 1'b0, 1'b0, 0);

        // Saturation high and low, then rounding on a half LSB.
        for (int t = 1; t < NTAPS; t++) load_tap(t, 0);
        load_tap(0, 16384);
        swap();
        send(1, 3000, 1'b1, 4095, 1'b1, 1'b0, 0);
        load_tap(0, -8192);
        swap();
        send(1, 100, 1'b1, 0, 1'b1, 1'b0, 0);
        load_tap(0, 4096);
        swap();
        send(1, 3, 1'b1, 2, 1'b0, 1'b0, 0);

        // Coefficient update during MAC: old bank in flight, new bank next.
        send(3, 2000, 1'b1, 1000, 1'b0, 1'b1, 8192);
        send(3, 400, 1'b1, 400, 1'b0, 1'b0, 0);

        // Bypass, then a one-sample delay reads the bypassed sample back.
        send(3, 1234, 1'b0, 1234, 1'b0, 1'b0, 0);
        load_tap(0, 0);
        load_tap(1, 8192);
        swap();
        send(3, 5, 1'b1, 1234, 1'b0, 1'b0, 0);

        // Reset in the middle of a computation.
        IN_VALID = 1'b1;
        IN_CH    = 2'd0;
        DATA_IN  = 12'd999;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        repeat (5) @(negedge CLK);
        RSTn = 1'b0;
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < NTAPS + 5; i++) begin
            @(negedge CLK);
            if (OUT_VALID) seen = 1'b1;
        end
        check("abort_no_out", int'(seen), 0);
        check_reset_vals();

        // Coefficients back to identity and ch3 history cleared.
        send(3, 777, 1'b1, 777, 1'b0, 1'b0, 0);
        // Ch2 history cleared: averaging filter sees a single sample.
        for (int t = 0; t < NTAPS; t++) load_tap(t, 512);
        swap();
        send(2, 1600, 1'b1, 100, 1'b0, 1'b0, 0);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
